// File: rtl/turn_signal_pkg.sv
// Shared types for the turn-signal arbiter: grant encoding and blink phase levels.
// Pure types/constants, no timing or flow control.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    GRANT_IDLE   = 2'd0,
    GRANT_LEFT   = 2'd1,
    GRANT_RIGHT  = 2'd2,
    GRANT_HAZARD = 2'd3
  } grant_t;

  localparam logic PHASE_ON  = 1'b1;
  localparam logic PHASE_OFF = 1'b0;

endpackage

// File: rtl/turn_signal_arbiter_blink_timebase.sv
// Blink prescaler: DIV-cycle phases, counts completed on+off cycles up to MIN_BLINKS.
// Registered state, restart takes effect on the next edge; no backpressure.
module blink_timebase
  import turn_signal_pkg::*;
#(
  parameter int DIV        = 100,
  parameter int MIN_BLINKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  input  logic en_i,
  output logic phase_o,
  output logic off_end_o,
  output logic min_done_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(MIN_BLINKS + 1);
  localparam logic [CW-1:0] CNT_MAX      = CW'(DIV - 1);
  localparam logic [BW-1:0] BLINKS_MAX   = BW'(MIN_BLINKS);
  localparam logic [BW-1:0] BLINKS_LAST  = BW'(MIN_BLINKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] blinks_q, blinks_d;
  logic          wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    blinks_d = blinks_q;
    if (restart_i) begin
      cnt_d    = '0;
      phase_d  = PHASE_ON;
      blinks_d = '0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        if (phase_q == PHASE_OFF && blinks_q != BLINKS_MAX)
          blinks_d = blinks_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= PHASE_ON;
      blinks_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      blinks_q <= blinks_d;
    end
  end

  assign phase_o   = phase_q;
  assign off_end_o = (phase_q == PHASE_OFF) && wrap;
  // The cycle finishing at this off_end counts, so a release lands exactly on the last OFF cycle.
  assign min_done_o = (blinks_q == BLINKS_MAX) || (off_end_o && blinks_q == BLINKS_LAST);

endmodule

// File: rtl/turn_signal_arbiter.sv
// Arbitrates left/right/hazard/brake onto two indicator LEDs; grant registered, LEDs follow it combinationally.
// Request at edge n is visible after edge n; no backpressure. Brake overlay built only with BRAKE_OVERLAY_EN.
module turn_signal_arbiter
  import turn_signal_pkg::*;
#(
  parameter int DIV        = 100,
  parameter int MIN_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_hazard,
  input  logic       req_brake,
  output logic       led_left,
  output logic       led_right,
  output logic [1:0] grant,
  output logic       busy
);

  grant_t state_q, state_d;
  logic   phase, off_end, min_done, restart;
  logic   drv_left, drv_right;

  always_ff @(posedge clk) begin
    if (rst) state_q <= GRANT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      GRANT_IDLE: begin
        if      (req_hazard) state_d = GRANT_HAZARD;
        else if (req_left)   state_d = GRANT_LEFT;
        else if (req_right)  state_d = GRANT_RIGHT;
      end
      GRANT_LEFT: begin
        if      (req_hazard)                         state_d = GRANT_HAZARD;
        else if (!req_left && off_end && min_done)   state_d = GRANT_IDLE;
      end
      GRANT_RIGHT: begin
        if      (req_hazard)                         state_d = GRANT_HAZARD;
        else if (!req_right && off_end && min_done)  state_d = GRANT_IDLE;
      end
      GRANT_HAZARD: begin
        if (!req_hazard && off_end) state_d = GRANT_IDLE;
      end
      default: state_d = GRANT_IDLE;
    endcase
  end

  // Any entry into an owned state (including preemption) starts a fresh blink sequence.
  assign restart = (state_d != state_q) && (state_d != GRANT_IDLE);

  blink_timebase #(
    .DIV        (DIV),
    .MIN_BLINKS (MIN_BLINKS)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .restart_i  (restart),
    .en_i       (state_q != GRANT_IDLE),
    .phase_o    (phase),
    .off_end_o  (off_end),
    .min_done_o (min_done)
  );

  always_comb begin
    drv_left  = 1'b0;
    drv_right = 1'b0;
    case (state_q)
      GRANT_LEFT:   drv_left = phase;
      GRANT_RIGHT:  drv_right = phase;
      GRANT_HAZARD: begin
        drv_left  = phase;
        drv_right = phase;
      end
      default: ;
    endcase
  end

`ifdef BRAKE_OVERLAY_EN
  assign led_left  = drv_left  | (req_brake && (state_q == GRANT_IDLE || state_q == GRANT_RIGHT));
  assign led_right = drv_right | (req_brake && (state_q == GRANT_IDLE || state_q == GRANT_LEFT));
`else
  logic unused_brake;
  assign unused_brake = req_brake;
  assign led_left     = drv_left;
  assign led_right    = drv_right;
`endif

  assign grant = state_q;
  assign busy  = (state_q != GRANT_IDLE);

endmodule

// File: tb/tb_turn_signal_arbiter.sv
// Randomized + directed bench for turn_signal_arbiter against a time-since-grant reference model.
`timescale 1ns/1ps
module tb_turn_signal_arbiter;

  localparam int DIV        = 4;
  localparam int MIN_BLINKS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_left = 1'b0, req_right = 1'b0, req_hazard = 1'b0, req_brake = 1'b0;
  logic       led_left, led_right, busy;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;

  // Model: owner (0 idle,1 left,2 right,3 hazard) and cycles elapsed since the grant began.
  int m_owner = 0;
  int m_t     = 0;

  always #5 clk = ~clk;

  turn_signal_arbiter #(.DIV(DIV), .MIN_BLINKS(MIN_BLINKS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_left   (req_left),
    .req_right  (req_right),
    .req_hazard (req_hazard),
    .req_brake  (req_brake),
    .led_left   (led_left),
    .led_right  (led_right),
    .grant      (grant),
    .busy       (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit off_end;
    int done;
    bit own;
    off_end = ((m_t % (2 * DIV)) == (2 * DIV - 1));
    done    = (m_t + 1) / (2 * DIV);
    own     = (m_owner == 1) ? req_left : req_right;
    if (rst) begin
      m_owner = 0;
      m_t     = 0;
    end else begin
      case (m_owner)
        0: begin
          m_t = 0;
          if      (req_hazard) m_owner = 3;
          else if (req_left)   m_owner = 1;
          else if (req_right)  m_owner = 2;
        end
        1, 2: begin
          if (req_hazard) begin
            m_owner = 3;
            m_t     = 0;
          end else if (off_end && !own && done >= MIN_BLINKS) m_owner = 0;
          else m_t++;
        end
        default: begin
          if (off_end && !req_hazard) m_owner = 0;
          else m_t++;
        end
      endcase
    end
  endtask

  task automatic model_check();
    int el, er, ph;
    el = 0;
    er = 0;
    ph = (((m_t / DIV) % 2) == 0) ? 1 : 0;
    case (m_owner)
      1: el = ph;
      2: er = ph;
      3: begin el = ph; er = ph; end
      default: ;
    endcase
`ifdef BRAKE_OVERLAY_EN
    if (req_brake && m_owner != 3) begin
      if (m_owner != 1) el = 1;
      if (m_owner != 2) er = 1;
    end
`endif
    chk("grant", grant, m_owner);
    chk("busy", busy, (m_owner != 0) ? 1 : 0);
    chk("led_left", led_left, el);
    chk("led_right", led_right, er);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic wait_grant(input string tag, input int g, input int budget);
    int n;
    n = 0;
    while (int'(grant) != g && n < budget) begin
      tick();
      n++;
    end
    chk(tag, grant, g);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat;
    pat = 16'b1111_0000_1111_0000;

    rst = 1'b1;
    tick();
    tick();
    chk("init_grant", grant, 0);
    chk("init_leds", {led_left, led_right}, 0);
    rst = 1'b0;

    // Reset while a left grant is active
    req_left = 1'b1;
    tick();
    tick();
    tick();
    chk("left_active", grant, 1);
    rst = 1'b1;
    tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_led_left", led_left, 0);
    chk("rst_led_right", led_right, 0);
    chk("rst_cnt", int'(dut.u_timebase.cnt_q), 0);
    rst = 1'b0;
    req_left = 1'b0;
    tick();

    // Single-cycle left pulse holds for MIN_BLINKS full cycles
    req_left = 1'b1;
    tick();
    req_left = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("pulse_grant", grant, 1);
      chk("pulse_led_left", led_left, int'(pat[15 - i]));
      chk("pulse_led_right", led_right, 0);
      tick();
    end
    chk("pulse_release", grant, 0);

    // Both sides requested: left wins, right follows after one idle cycle
    req_left  = 1'b1;
    req_right = 1'b1;
    tick();
    chk("both_left_first", grant, 1);
    req_left = 1'b0;
    wait_grant("both_idle_gap", 0, 40);
    tick();
    chk("both_right_next", grant, 2);
    chk("both_right_led", led_right, 1);
    req_right = 1'b0;
    wait_grant("right_release", 0, 40);

    // Hazard preempts left at cycle 5, released after the following OFF phase
    req_left = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    req_hazard = 1'b1;
    req_left   = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("haz_grant", grant, 3);
      chk("haz_leds", {led_left, led_right}, (i < 4) ? 3 : 0);
      if (i == 1) req_hazard = 1'b0;
      tick();
    end
    chk("haz_release", grant, 0);

    // Brake overlay
    req_brake = 1'b1;
    tick();
`ifdef BRAKE_OVERLAY_EN
    chk("brake_idle_leds", {led_left, led_right}, 3);
    chk("brake_idle_grant", grant, 0);
    req_right = 1'b1;
    tick();
    req_right = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("brake_right_left", led_left, 1);
      chk("brake_right_right", led_right, (i < 4) ? 1 : 0);
      tick();
    end
    req_hazard = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("brake_haz_leds", {led_left, led_right}, (i < 4) ? 3 : 0);
      tick();
    end
    req_hazard = 1'b0;
`else
    chk("nobrake_idle_leds", {led_left, led_right}, 0);
`endif
    req_brake = 1'b0;
    wait_grant("brake_release", 0, 40);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  req_left   = ~req_left;
      if ($urandom_range(7) == 0)  req_right  = ~req_right;
      if ($urandom_range(23) == 0) req_hazard = ~req_hazard;
      if ($urandom_range(5) == 0)  req_brake  = ~req_brake;
      rst = ($urandom_range(255) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
